freq_meter_mc: RTL and testbench
================================

FREQ_METER_MC -- requirements
Module: freq_meter_mc

Interface
REQ-001 Parameter CH_NUM, default 4: number of measured input channels, range 1..8.
REQ-002 Parameter CLK_FREQ, default 50_000_000: sys_clk frequency in Hz.
REQ-003 Parameter GATE_CYCLES, default 50_000_000: software gate length in sys_clk cycles.
REQ-004 Parameter TIMEOUT_CYCLES, default 100_000_000: edge-wait limit in sys_clk cycles.
REQ-005 Parameter CNT_W, default 32: width of the edge counter X and the clock counter Y.
REQ-006 Parameter FREQ_W, default 32: width of the frequency result.
REQ-007 sys_clk  in  1  single clock; all logic on its rising edge.
REQ-008 sys_rst_n  in  1  asynchronous, active-low reset.
REQ-009 sig_in  in  CH_NUM  asynchronous test signals, one bit per channel.
REQ-010 ch_en  in  CH_NUM  channel enable mask.
REQ-011 start  in  1  one-cycle pulse that begins a sweep.
REQ-012 cont_mode  in  1  1 = sweep repeats forever; 0 = one sweep per start.
REQ-013 freq_data  out  FREQ_W  measured frequency in Hz.
REQ-014 freq_ch  out  clog2(CH_NUM) (min 1)  channel index of freq_data.
REQ-015 freq_err  out  1  1 = timeout result; freq_data is 0.
REQ-016 freq_valid  out  1  result present.
REQ-017 freq_ready  in  1  consumer accepts the result.
REQ-018 busy  out  1  high from sweep start until the sweep completes.

Function
REQ-019 Each sig_in bit passes through a 2-FF synchroniser; a rising edge is a registered 0->1 on the synchronised bit. Signals up to CLK_FREQ/4 are supported.
REQ-020 A sweep visits enabled channels in ascending index order, one at a time, and skips disabled channels.
REQ-021 The FSM has states IDLE, ARM, GATE, CLOSE, DIV, OUT.
REQ-022 IDLE -> ARM on start when ch_en != 0. The FSM also leaves OUT toward ARM when cont_mode=1. ch_en == 0 keeps the FSM in IDLE.
REQ-023 ARM: wait for a rising edge on the selected channel, then -> GATE. X and Y clear to 0 at that edge.
REQ-024 GATE: Y increments every cycle and X increments on each rising edge. After GATE_CYCLES cycles in GATE -> CLOSE.
REQ-025 CLOSE: counting continues. The first rising edge strictly after entry closes the gate, is counted in X, and -> DIV.
REQ-026 X and Y saturate at all-ones and never wrap.
REQ-027 In ARM or CLOSE, TIMEOUT_CYCLES without an edge -> OUT with freq_data=0 and freq_err=1.
REQ-028 DIV computes freq = floor(X*CLK_FREQ / Y) with a restoring divider that produces one quotient bit per cycle.
REQ-029 If the quotient exceeds FREQ_W bits, freq_data saturates to all-ones.
REQ-030 OUT drives freq_valid=1 with freq_data, freq_ch and freq_err stable until the cycle where freq_ready=1.
REQ-031 On that handshake cycle the FSM advances to the next enabled channel (ARM), or, after the last enabled channel, goes to IDLE (cont_mode=0) or wraps to the lowest enabled channel (cont_mode=1).
REQ-032 start while busy=1 is ignored.
REQ-033 ch_en changes are sampled only when the next channel is selected.
REQ-034 Deasserting cont_mode mid-sweep completes the current sweep, then IDLE.

Reset
REQ-035 While sys_rst_n=0:
- FSM = IDLE; X, Y and divider state = 0.
- freq_data=0, freq_ch=0, freq_err=0, freq_valid=0, busy=0.
- Synchroniser flops = 0.
REQ-036 Reset asserted mid-operation aborts immediately. A pending result is discarded and no freq_valid appears after release until a new start.

Structure
REQ-037 Package freq_meter_pkg holds the FSM state encoding, the default CLK_FREQ, and the index-width function.
REQ-038 Sub-module freq_div (parametrised sequential restoring divider) has the interface start/numerator/denominator -> done/quotient. The product width is CNT_W+clog2(CLK_FREQ+1).

Verification
All scenarios use CLK_FREQ=50_000_000, GATE_CYCLES=240, TIMEOUT_CYCLES=400, CH_NUM=4.
REQ-039 Scenario 1: ch0 period 20 clocks, ch_en=0001, start, freq_ready=1 -> one result: freq_data=2_500_000, freq_ch=0, freq_err=0; then busy=0.
REQ-040 Scenario 2: ch2 period 7 clocks, ch_en=0100 -> freq_data=7_142_857 (truncated).
REQ-041 Scenario 3: ch_en=0101, cont_mode=1, ch0 period 10, ch2 period 25 -> results alternate ch0=5_000_000 and ch2=2_000_000 for at least 3 sweeps.
REQ-042 Scenario 4: ch1 held constant at 0, ch_en=0010 -> 400 cycles after ARM entry, freq_valid=1 with freq_err=1 and freq_data=0.
REQ-043 Scenario 5: hold freq_ready=0 for 50 cycles after freq_valid -> freq_data, freq_ch and freq_err stay constant; exactly one transfer occurs when ready rises.
REQ-044 Scenario 6: sys_rst_n=0 during GATE, start pulse while busy, and ch_en=0 with start -> all outputs return to reset values; no valid is produced and busy stays 0.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared definitions for the multi-channel frequency meter: FSM encoding,
// default clock rate and the channel-index width helper.
package freq_meter_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StGate,
    StClose,
    StDiv,
    StOut
  } fm_state_e;

  localparam int unsigned DEF_CLK_FREQ = 50_000_000;

  // Width of a channel index; a single channel still gets one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/freq_div.sv
// Sequential restoring divider: one quotient bit per cycle, NUM_W cycles per
// division, done pulses for one cycle when quotient is final.
module freq_div
  import freq_meter_pkg::*;
#(
  parameter int unsigned NUM_W = 58,
  parameter int unsigned DEN_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] numerator,
  input  logic [DEN_W-1:0] denominator,
  output logic             done,
  output logic [NUM_W-1:0] quotient
);
  localparam int unsigned CW = $clog2(NUM_W + 1);

  logic [NUM_W-1:0] quo_q;
  logic [DEN_W-1:0] rem_q;
  logic [DEN_W-1:0] den_q;
  logic [CW-1:0]    cnt_q;
  logic             done_q;
  logic [DEN_W:0]   shifted;
  logic [DEN_W:0]   trial;

  // The remainder stays below the divisor, so a set trial MSB means "no subtract".
  assign shifted = {rem_q, quo_q[NUM_W-1]};
  assign trial   = shifted - {1'b0, den_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        quo_q <= numerator;
        rem_q <= '0;
        den_q <= denominator;
        cnt_q <= CW'(NUM_W);
      end else if (cnt_q != '0) begin
        if (!trial[DEN_W]) begin
          rem_q <= trial[DEN_W-1:0];
          quo_q <= {quo_q[NUM_W-2:0], 1'b1};
        end else begin
          rem_q <= shifted[DEN_W-1:0];
          quo_q <= {quo_q[NUM_W-2:0], 1'b0};
        end
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) done_q <= 1'b1;
      end
    end
  end

  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/freq_meter_mc.sv
// Multi-channel reciprocal frequency meter: counts whole input periods (X)
// against sys_clk cycles (Y) over a gate and reports X*CLK_FREQ/Y per channel.
module freq_meter_mc
  import freq_meter_pkg::*;
#(
  parameter int unsigned CH_NUM         = 4,
  parameter int unsigned CLK_FREQ       = DEF_CLK_FREQ,
  parameter int unsigned GATE_CYCLES    = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned FREQ_W         = 32
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic [CH_NUM-1:0]        sig_in,
  input  logic [CH_NUM-1:0]        ch_en,
  input  logic                     start,
  input  logic                     cont_mode,
  output logic [FREQ_W-1:0]        freq_data,
  output logic [idx_w(CH_NUM)-1:0] freq_ch,
  output logic                     freq_err,
  output logic                     freq_valid,
  input  logic                     freq_ready,
  output logic                     busy
);
  localparam int unsigned IW      = idx_w(CH_NUM);
  localparam int unsigned PW      = CNT_W + $clog2(CLK_FREQ + 1);
  localparam int unsigned CYC_MAX = (GATE_CYCLES > TIMEOUT_CYCLES) ? GATE_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);
  localparam logic [CYC_W-1:0] GateLast = CYC_W'(GATE_CYCLES - 1);
  localparam logic [CYC_W-1:0] TmoLast  = CYC_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0]    QuoMax   = PW'({FREQ_W{1'b1}});

  logic [CH_NUM-1:0] sync1_q, sync2_q, sync3_q, rise;
  fm_state_e         state_q, state_d;
  logic [IW-1:0]     sel_q, sel_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0]  x_q, x_d, y_q, y_d;
  logic [FREQ_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic              sel_rise, div_start, div_done;
  logic [PW-1:0]     div_num, div_quo;
  logic              nxt_found, first_found;
  logic [IW-1:0]     nxt_idx, first_idx;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rise     = sync2_q & ~sync3_q;
  assign sel_rise = rise[sel_q];

  // Lowest enabled channel overall, and lowest enabled channel above the current one.
  always_comb begin
    nxt_found   = 1'b0;
    nxt_idx     = '0;
    first_found = 1'b0;
    first_idx   = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (ch_en[i]) begin
        first_found = 1'b1;
        first_idx   = IW'(i);
        if (i > int'(sel_q)) begin
          nxt_found = 1'b1;
          nxt_idx   = IW'(i);
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cyc_d     = cyc_q;
    x_d       = x_q;
    y_d       = y_q;
    data_d    = data_q;
    err_d     = err_q;
    div_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && first_found) begin
          state_d = StArm;
          sel_d   = first_idx;
          cyc_d   = '0;
        end
      end
      StArm: begin
        if (sel_rise) begin
          state_d = StGate;
          x_d     = '0;
          y_d     = '0;
          cyc_d   = '0;
        end else if (cyc_q == TmoLast) begin
          state_d = StOut;
          data_d  = '0;
          err_d   = 1'b1;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      StGate: begin
        if (y_q != '1) y_d = y_q + CNT_W'(1);
        if (sel_rise && (x_q != '1)) x_d = x_q + CNT_W'(1);
        if (cyc_q == GateLast) begin
          state_d = StClose;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      StClose: begin
        if (y_q != '1) y_d = y_q + CNT_W'(1);
        if (sel_rise) begin
          if (x_q != '1) x_d = x_q + CNT_W'(1);
          state_d   = StDiv;
          div_start = 1'b1;
        end else if (cyc_q == TmoLast) begin
          state_d = StOut;
          data_d  = '0;
          err_d   = 1'b1;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      StDiv: begin
        if (div_done) begin
          state_d = StOut;
          err_d   = 1'b0;
          data_d  = (div_quo > QuoMax) ? '1 : FREQ_W'(div_quo);
        end
      end
      StOut: begin
        if (freq_ready) begin
          cyc_d = '0;
          if (nxt_found) begin
            state_d = StArm;
            sel_d   = nxt_idx;
          end else if (cont_mode && first_found) begin
            state_d = StArm;
            sel_d   = first_idx;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
      sel_q   <= '0;
      cyc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cyc_q   <= cyc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // The divider latches its operands on start, so feed it the closing-edge counts.
  assign div_num = PW'(x_d) * PW'(CLK_FREQ);

  freq_div #(
    .NUM_W(PW),
    .DEN_W(CNT_W)
  ) u_div (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .start      (div_start),
    .numerator  (div_num),
    .denominator(y_d),
    .done       (div_done),
    .quotient   (div_quo)
  );

  assign freq_data  = data_q;
  assign freq_ch    = sel_q;
  assign freq_err   = err_q;
  assign freq_valid = (state_q == StOut);
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_freq_meter_mc.sv
// Self-checking bench for freq_meter_mc: table of single-channel measurements,
// hand-written corner sequences and randomized sweeps against a period model.
module tb_freq_meter_mc;
  localparam int unsigned CH_NUM         = 4;
  localparam int unsigned CLK_FREQ       = 50_000_000;
  localparam int unsigned GATE_CYCLES    = 240;
  localparam int unsigned TIMEOUT_CYCLES = 400;
  localparam int          WAIT_BUDGET    = 2000;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [3:0]  sig_in;
  logic [3:0]  ch_en;
  logic        start;
  logic        cont_mode;
  logic [31:0] freq_data;
  logic [1:0]  freq_ch;
  logic        freq_err;
  logic        freq_valid;
  logic        freq_ready;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // Square-wave period per channel in sys_clk cycles; 0 holds the line low.
  int unsigned per [4];
  int unsigned ph  [4];

  typedef struct packed {
    logic [3:0]      en;
    logic [3:0][7:0] per;
    logic [1:0]      exp_ch;
    logic [31:0]     exp_data;
  } vec_t;

  vec_t vecs [5];

  freq_meter_mc #(
    .CH_NUM        (CH_NUM),
    .CLK_FREQ      (CLK_FREQ),
    .GATE_CYCLES   (GATE_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (32),
    .FREQ_W        (32)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .sig_in    (sig_in),
    .ch_en     (ch_en),
    .start     (start),
    .cont_mode (cont_mode),
    .freq_data (freq_data),
    .freq_ch   (freq_ch),
    .freq_err  (freq_err),
    .freq_valid(freq_valid),
    .freq_ready(freq_ready),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    sig_in = '0;
    for (int c = 0; c < 4; c++) begin
      per[c] = 0;
      ph[c]  = 0;
    end
    forever begin
      @(negedge sys_clk);
      for (int c = 0; c < 4; c++) begin
        if (per[c] == 0) begin
          ph[c]     = 0;
          sig_in[c] = 1'b0;
        end else begin
          ph[c]     = (ph[c] + 1 >= per[c]) ? 0 : ph[c] + 1;
          sig_in[c] = (ph[c] < per[c] / 2);
        end
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  // Whole periods over whole cycles reduces to CLK_FREQ / period.
  function automatic logic [63:0] exp_freq(input int unsigned p);
    return (p == 0) ? 64'd0 : 64'(CLK_FREQ / p);
  endfunction

  function automatic vec_t mk(input logic [3:0] en, input int unsigned p0, input int unsigned p1,
                              input int unsigned p2, input int unsigned p3,
                              input int unsigned ch, input int unsigned data);
    vec_t v;
    v.en       = en;
    v.per[0]   = 8'(p0);
    v.per[1]   = 8'(p1);
    v.per[2]   = 8'(p2);
    v.per[3]   = 8'(p3);
    v.exp_ch   = 2'(ch);
    v.exp_data = data;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge sys_clk);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic get_result(input bit rand_rdy, output logic [1:0] ch, output logic [31:0] data,
                            output logic err);
    bit ok;
    ok   = 1'b0;
    ch   = '0;
    data = '0;
    err  = 1'b0;
    for (int n = 0; n < WAIT_BUDGET && !ok; n++) begin
      @(negedge sys_clk);
      if (rand_rdy) freq_ready = ($urandom_range(0, 2) != 0);
      if (freq_valid && freq_ready) begin
        ch   = freq_ch;
        data = freq_data;
        err  = freq_err;
        ok   = 1'b1;
      end
    end
    freq_ready = 1'b1;
    check("result_wait", 64'(ok), 64'd1);
  endtask

  task automatic check_sweep(input logic [3:0] en, input bit rand_rdy, input string tag);
    logic [1:0]  rc;
    logic [31:0] rd;
    logic        re;
    for (int c = 0; c < 4; c++) begin
      if (en[c]) begin
        get_result(rand_rdy, rc, rd, re);
        check({tag, "_ch"}, 64'(rc), 64'(c));
        check({tag, "_data"}, 64'(rd), exp_freq(per[c]));
        check({tag, "_err"}, 64'(re), 64'(per[c] == 0));
      end
    end
  endtask

  task automatic check_quiet(input int cycles, input string tag);
    int vcnt;
    int bcnt;
    vcnt = 0;
    bcnt = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge sys_clk);
      if (freq_valid) vcnt++;
      if (busy) bcnt++;
    end
    check({tag, "_valid_cnt"}, 64'(vcnt), 64'd0);
    check({tag, "_busy_cnt"}, 64'(bcnt), 64'd0);
  endtask

  task automatic set_periods(input int unsigned p0, input int unsigned p1,
                             input int unsigned p2, input int unsigned p3);
    per[0] = p0;
    per[1] = p1;
    per[2] = p2;
    per[3] = p3;
    repeat (50) @(negedge sys_clk);
  endtask

  initial begin
    logic [1:0]  rc;
    logic [31:0] rd;
    logic        re;
    logic [3:0]  en_r;
    int          n;
    int          xf;

    sys_rst_n  = 1'b0;
    ch_en      = '0;
    start      = 1'b0;
    cont_mode  = 1'b0;
    freq_ready = 1'b1;

    vecs[0] = mk(4'b0001, 20, 0, 0, 0, 0, 2_500_000);
    vecs[1] = mk(4'b0100, 5, 9, 7, 0, 2, 7_142_857);
    vecs[2] = mk(4'b1000, 0, 0, 0, 4, 3, 12_500_000);
    vecs[3] = mk(4'b0001, 33, 6, 0, 8, 0, 1_515_151);
    vecs[4] = mk(4'b0100, 0, 0, 13, 0, 2, 3_846_153);

    repeat (3) @(negedge sys_clk);
    check("rst_data", 64'(freq_data), 64'd0);
    check("rst_ch", 64'(freq_ch), 64'd0);
    check("rst_err", 64'(freq_err), 64'd0);
    check("rst_valid", 64'(freq_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    sys_rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      set_periods(32'(vecs[i].per[0]), 32'(vecs[i].per[1]), 32'(vecs[i].per[2]),
                  32'(vecs[i].per[3]));
      ch_en = vecs[i].en;
      pulse_start();
      get_result(1'b0, rc, rd, re);
      check($sformatf("vec%0d_ch", i), 64'(rc), 64'(vecs[i].exp_ch));
      check($sformatf("vec%0d_data", i), 64'(rd), 64'(vecs[i].exp_data));
      check($sformatf("vec%0d_err", i), 64'(re), 64'd0);
      @(negedge sys_clk);
      check($sformatf("vec%0d_busy_end", i), 64'(busy), 64'd0);
    end

    // Result held under backpressure, then exactly one transfer.
    set_periods(20, 0, 0, 0);
    ch_en      = 4'b0001;
    freq_ready = 1'b0;
    pulse_start();
    n = 0;
    while (!freq_valid && n < WAIT_BUDGET) begin
      @(negedge sys_clk);
      n++;
    end
    check("bp_valid_seen", 64'(freq_valid), 64'd1);
    for (int k = 0; k < 50; k++) begin
      @(negedge sys_clk);
      check("bp_hold_valid", 64'(freq_valid), 64'd1);
      check("bp_hold_data", 64'(freq_data), 64'd2_500_000);
      check("bp_hold_ch", 64'(freq_ch), 64'd0);
      check("bp_hold_err", 64'(freq_err), 64'd0);
    end
    freq_ready = 1'b1;
    xf = 0;
    for (int k = 0; k < 20; k++) begin
      if (freq_valid && freq_ready) xf++;
      @(negedge sys_clk);
    end
    check("bp_transfers", 64'(xf), 64'd1);
    check("bp_busy_end", 64'(busy), 64'd0);

    // Reset in the middle of a gate aborts and discards the measurement.
    set_periods(0, 0, 20, 0);
    ch_en = 4'b0100;
    pulse_start();
    repeat (100) @(negedge sys_clk);
    check("gate_busy", 64'(busy), 64'd1);
    sys_rst_n = 1'b0;
    #1;
    check("midrst_data", 64'(freq_data), 64'd0);
    check("midrst_ch", 64'(freq_ch), 64'd0);
    check("midrst_err", 64'(freq_err), 64'd0);
    check("midrst_valid", 64'(freq_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    check_quiet(800, "post_rst");

    // Silent channel times out a fixed number of cycles after arming.
    set_periods(10, 0, 10, 10);
    ch_en = 4'b0010;
    pulse_start();
    n = 0;
    while (!freq_valid && n < 1000) begin
      @(negedge sys_clk);
      n++;
    end
    check("tmo_latency", 64'(n), 64'(TIMEOUT_CYCLES));
    check("tmo_err", 64'(freq_err), 64'd1);
    check("tmo_data", 64'(freq_data), 64'd0);
    check("tmo_ch", 64'(freq_ch), 64'd1);
    @(negedge sys_clk);
    @(negedge sys_clk);
    check("tmo_busy_end", 64'(busy), 64'd0);

    // A second start while busy must not add a result.
    set_periods(20, 0, 0, 0);
    ch_en = 4'b0001;
    pulse_start();
    repeat (30) @(negedge sys_clk);
    pulse_start();
    check_sweep(4'b0001, 1'b0, "busy_start");
    @(negedge sys_clk);
    check("busy_start_end", 64'(busy), 64'd0);
    check_quiet(600, "busy_start_after");

    ch_en = 4'b0000;
    pulse_start();
    check_quiet(20, "no_chan");

    // Continuous mode alternates channels; clearing it finishes the sweep.
    set_periods(10, 0, 25, 0);
    ch_en     = 4'b0101;
    cont_mode = 1'b1;
    pulse_start();
    for (int s = 0; s < 3; s++) check_sweep(4'b0101, 1'b0, $sformatf("cont%0d", s));
    @(negedge sys_clk);
    cont_mode = 1'b0;
    check_sweep(4'b0101, 1'b0, "cont_last");
    @(negedge sys_clk);
    check("cont_busy_end", 64'(busy), 64'd0);
    check_quiet(600, "cont_after");

    for (int it = 0; it < 8; it++) begin
      en_r = 4'($urandom_range(1, 15));
      for (int c = 0; c < 4; c++) begin
        per[c] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(4, 40);
      end
      repeat (50) @(negedge sys_clk);
      ch_en = en_r;
      pulse_start();
      check_sweep(en_r, 1'b1, $sformatf("rnd%0d", it));
      @(negedge sys_clk);
      check($sformatf("rnd%0d_busy_end", it), 64'(busy), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
